// File: rtl/compare_output_channel_if.sv
// Signal bundle for compare_output_channel: control strobes in, channel status out.
// The slave modport is the channel's view; the master modport is the driver's view.
interface compare_output_channel_if #(
  parameter int WIDTH = 16
);
  logic             ena;
  logic             arm;
  logic             abort;
  logic             on_match;
  logic             off_match;
  logic [WIDTH-1:0] max_dur;
  logic             out;
  logic             armed;
  logic             active;
  logic             done;
  logic             limit_hit;
  logic [WIDTH-1:0] dur;

  modport master (
    output ena, arm, abort, on_match, off_match, max_dur,
    input  out, armed, active, done, limit_hit, dur
  );

  modport slave (
    input  ena, arm, abort, on_match, off_match, max_dur,
    output out, armed, active, done, limit_hit, dur
  );
endinterface

// File: rtl/compare_output_channel.sv
// Gated output channel: arm, fire on on_match, release on off_match, measures high time.
// Optional dwell limit enabled by defining CHANNEL_DWELL_LIMIT_EN.
module compare_output_channel #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       srst,
  compare_output_channel_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic             limit_reached;

`ifdef CHANNEL_DWELL_LIMIT_EN
  // Equality only: lowering max_dur below cnt mid-pulse never fires.
  assign limit_reached = (bus.max_dur != '0) && (cnt == bus.max_dur);
`else
  logic unused_max_dur;
  assign unused_max_dur = ^bus.max_dur;
  assign limit_reached  = 1'b0;
`endif

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bus.out       <= 1'b0;
      bus.armed     <= 1'b0;
      bus.active    <= 1'b0;
      bus.done      <= 1'b0;
      bus.limit_hit <= 1'b0;
      bus.dur       <= '0;
    end else if (srst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bus.out       <= 1'b0;
      bus.armed     <= 1'b0;
      bus.active    <= 1'b0;
      bus.done      <= 1'b0;
      bus.limit_hit <= 1'b0;
      bus.dur       <= '0;
    end else if (bus.ena) begin
      bus.done      <= 1'b0;
      bus.limit_hit <= 1'b0;
      if (bus.abort) begin
        state      <= ST_IDLE;
        cnt        <= '0;
        bus.out    <= 1'b0;
        bus.armed  <= 1'b0;
        bus.active <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.arm) begin
              state     <= ST_ARMED;
              bus.armed <= 1'b1;
            end
          end
          ST_ARMED: begin
            // off_match on the firing edge is deliberately not looked at.
            if (bus.on_match) begin
              state      <= ST_ACTIVE;
              cnt        <= {{(WIDTH-1){1'b0}}, 1'b1};
              bus.out    <= 1'b1;
              bus.armed  <= 1'b0;
              bus.active <= 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (bus.off_match) begin
              state      <= ST_IDLE;
              bus.out    <= 1'b0;
              bus.active <= 1'b0;
              bus.dur    <= cnt;
              bus.done   <= 1'b1;
            end else if (limit_reached) begin
              state         <= ST_IDLE;
              bus.out       <= 1'b0;
              bus.active    <= 1'b0;
              bus.dur       <= cnt;
              bus.limit_hit <= 1'b1;
            end else if (cnt != '1) begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state      <= ST_IDLE;
            bus.out    <= 1'b0;
            bus.armed  <= 1'b0;
            bus.active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_compare_output_channel.sv
// Randomized plus directed bench for compare_output_channel against a cycle-level
// model built from pulse bookkeeping (armed flag, live pulse length, last duration).
module tb_compare_output_channel;
  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef CHANNEL_DWELL_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst = 1'b0;
  logic srst = 1'b0;
  always #5 clk = ~clk;

  compare_output_channel_if #(.WIDTH(WIDTH)) bus ();

  compare_output_channel #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .arst (arst),
    .srst (srst),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference: a pulse is either pending (armed), live (active, length len) or absent.
  bit m_armed, m_active, m_done, m_lim;
  int m_len, m_dur;

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic check_value(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_active = 0; m_done = 0; m_lim = 0; m_len = 0; m_dur = 0;
  endtask

  task automatic model_edge(input bit e, input bit s, input bit a, input bit ab,
                            input bit on, input bit off, input int md);
    if (s) begin
      model_reset();
    end else if (e) begin
      m_done = 0;
      m_lim  = 0;
      if (ab) begin
        m_armed = 0; m_active = 0; m_len = 0;
      end else if (m_active) begin
        if (off) begin
          m_active = 0; m_dur = sat(m_len); m_done = 1;
        end else if (LIMIT_EN && md != 0 && sat(m_len) == md) begin
          m_active = 0; m_dur = sat(m_len); m_lim = 1;
        end else begin
          m_len++;
        end
      end else if (m_armed) begin
        if (on) begin
          m_armed = 0; m_active = 1; m_len = 1;
        end
      end else if (a) begin
        m_armed = 1;
      end
    end
  endtask

  task automatic compare_all();
    check_value("out",       int'(bus.out),       int'(m_active));
    check_value("armed",     int'(bus.armed),     int'(m_armed));
    check_value("active",    int'(bus.active),    int'(m_active));
    check_value("done",      int'(bus.done),      int'(m_done));
    check_value("limit_hit", int'(bus.limit_hit), int'(m_lim));
    check_value("dur",       int'(bus.dur),       m_dur);
  endtask

  // Called at a negedge: apply inputs, clock once, then compare at the next negedge.
  task automatic cycle(input bit e, input bit s, input bit a, input bit ab,
                       input bit on, input bit off, input int md);
    bus.ena = e; srst = s; bus.arm = a; bus.abort = ab;
    bus.on_match = on; bus.off_match = off; bus.max_dur = WIDTH'(md);
    @(posedge clk);
    model_edge(e, s, a, ab, on, off, md);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n, input bit e);
    for (int i = 0; i < n; i++) cycle(e, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.ena = 0; bus.arm = 0; bus.abort = 0; bus.on_match = 0;
    bus.off_match = 0; bus.max_dur = '0;
    model_reset();
    repeat (2) @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    compare_all();
    $display("reset state checked");

    // arm, on at t, off at t+5
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0);
    idle(4, 1);
    cycle(1, 0, 0, 0, 0, 1, 0);
    check_value("dur_basic", int'(bus.dur), 5);
    check_value("done_basic", int'(bus.done), 1);
    idle(1, 1);
    check_value("done_one_cycle", int'(bus.done), 0);
    $display("basic pulse: dur=%0d", bus.dur);

    // on and off together while armed: fire, ignore off
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 1, 0);
    check_value("same_cycle_active", int'(bus.active), 1);
    idle(2, 1);
    cycle(1, 0, 1, 0, 0, 1, 0);   // arm on release edge is ignored
    idle(1, 1);
    check_value("rearm_ignored", int'(bus.armed), 0);
    $display("same-cycle on/off: dur=%0d", bus.dur);

    // ena frozen for 4 cycles mid-pulse
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0);
    idle(2, 1);
    idle(4, 0);
    check_value("frozen_out", int'(bus.out), 1);
    idle(2, 1);
    cycle(1, 0, 0, 0, 0, 1, 0);
    check_value("dur_frozen", int'(bus.dur), 5);
    $display("ena freeze: dur=%0d", bus.dur);

`ifdef CHANNEL_DWELL_LIMIT_EN
    cycle(1, 0, 1, 0, 0, 0, 3);
    cycle(1, 0, 0, 0, 1, 0, 3);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, 3);
    check_value("limit_pulse", int'(bus.limit_hit), 1);
    check_value("dur_limit", int'(bus.dur), 3);
    $display("dwell limit: dur=%0d", bus.dur);
`endif

    // saturation: 21 high cycles into a 4-bit counter
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0);
    idle(20, 1);
    cycle(1, 0, 0, 0, 0, 1, 0);
    check_value("dur_saturated", int'(bus.dur), MAXV);
    $display("saturation: dur=%0d", bus.dur);

    // async reset while active, no clock edge needed
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0);
    idle(2, 1);
    #2 arst = 1'b0;
    #1;
    model_reset();
    check_value("arst_out", int'(bus.out), 0);
    check_value("arst_active", int'(bus.active), 0);
    check_value("arst_dur", int'(bus.dur), 0);
    @(negedge clk);
    arst = 1'b1;
    compare_all();
    $display("async reset mid-pulse checked");

    // abort mid-pulse keeps dur, no pulse
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0);
    idle(2, 1);
    cycle(1, 0, 0, 0, 0, 1, 0);
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0, 1, 0);
    check_value("abort_done", int'(bus.done), 0);
    check_value("abort_dur", int'(bus.dur), 3);
    $display("abort checked");

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(99) < 90), ($urandom_range(199) == 0),
            ($urandom_range(99) < 30), ($urandom_range(99) < 3),
            ($urandom_range(99) < 25), ($urandom_range(99) < 12),
            int'($urandom_range(MAXV)));
    end
    $display("random phase: 3000 cycles");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
